// File: rtl/conv_window_scheduler_pkg.sv
// Shared types and helpers for the convolution window scheduler.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FIRE,
        WAIT,
        WRITE,
        DONE
    } sched_state_t;

    function automatic int unsigned out_dim(
        input int unsigned size,
        input int unsigned sizeker,
        input int unsigned stride
    );
        return (size - sizeker) / stride + 1;
    endfunction

endpackage

// File: rtl/conv_window_scheduler_counter.sv
// Raster (row, col) output-position counter; col runs fastest, last flags the final position.
module window_index_counter
    import conv_pkg::*;
#(
    parameter int unsigned OUT_DIM = 5,
    parameter int unsigned IDX_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             last
);

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(OUT_DIM - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col == MAX_IDX) begin
                col <= '0;
                row <= row + IDX_W'(1);
            end else begin
                col <= col + IDX_W'(1);
            end
        end
    end

    always_comb begin
        last = (row == MAX_IDX) && (col == MAX_IDX);
    end

endmodule

// File: rtl/conv_window_scheduler.sv
// Sequences a shared conv engine over all output positions of one layer pass.
// Define CONV_SCHED_RELU_EN to clamp negative engine results to zero on capture.
module conv_window_scheduler
    import conv_pkg::*;
#(
    parameter int unsigned SIZE      = 7,
    parameter int unsigned SIZEKER   = 3,
    parameter int unsigned STRIDE    = 1,
    parameter int unsigned WIDTH_BIT = 8,
    parameter int unsigned IDX_W     = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [IDX_W-1:0]            win_row,
    output logic [IDX_W-1:0]            win_col,
    output logic                        eng_load,
    output logic                        eng_start,
    input  logic                        eng_valid,
    input  logic signed [WIDTH_BIT-1:0] eng_result,
    output logic                        out_we,
    output logic [IDX_W-1:0]            out_row,
    output logic [IDX_W-1:0]            out_col,
    output logic signed [WIDTH_BIT-1:0] out_data,
    input  logic                        out_ready
);

    localparam int unsigned      OUT_DIM = out_dim(SIZE, SIZEKER, STRIDE);
    localparam logic [IDX_W-1:0] STEP    = IDX_W'(STRIDE);

    sched_state_t                state;
    logic signed [WIDTH_BIT-1:0] result;
    logic signed [WIDTH_BIT-1:0] captured;
    logic [IDX_W-1:0]            idx_i;
    logic [IDX_W-1:0]            idx_j;
    logic                        idx_last;
    logic                        cnt_clear;
    logic                        cnt_advance;

    // Indices return to zero at pass end so an idle scheduler presents origin (0,0).
    always_comb begin
        cnt_clear   = ((state == IDLE) && start) || (state == DONE);
        cnt_advance = (state == WRITE) && out_ready && !idx_last;
    end

    window_index_counter #(
        .OUT_DIM (OUT_DIM),
        .IDX_W   (IDX_W)
    ) u_index (
        .clock   (clock),
        .reset   (reset),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .row     (idx_i),
        .col     (idx_j),
        .last    (idx_last)
    );

    always_comb begin
`ifdef CONV_SCHED_RELU_EN
        captured = eng_result[WIDTH_BIT-1] ? '0 : eng_result;
`else
        captured = eng_result;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            result    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            eng_load  <= 1'b0;
            eng_start <= 1'b0;
            out_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        eng_load <= 1'b1;
                    end
                end
                LOAD: begin
                    state     <= FIRE;
                    eng_load  <= 1'b0;
                    eng_start <= 1'b1;
                end
                FIRE: begin
                    state     <= WAIT;
                    eng_start <= 1'b0;
                end
                WAIT: begin
                    if (eng_valid) begin
                        state  <= WRITE;
                        result <= captured;
                        out_we <= 1'b1;
                    end
                end
                WRITE: begin
                    if (out_ready) begin
                        out_we <= 1'b0;
                        if (idx_last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= LOAD;
                            eng_load <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        win_row  = idx_i * STEP;
        win_col  = idx_j * STEP;
        out_row  = idx_i;
        out_col  = idx_j;
        out_data = result;
    end

endmodule
